// File: rtl/enum_rr_arbiter_if.sv
// Request/beat bus between two requesters and the round-robin arbiter.
interface enum_rr_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_a;
    logic             last_a;
    logic [WIDTH-1:0] data_a;
    logic             req_b;
    logic             last_b;
    logic [WIDTH-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       state_o;
    logic [3:0]       hold_cnt;

    // Requester side: drives beats, observes grants and the shared output.
    modport master (
        output req_a, last_a, data_a, req_b, last_b, data_b,
        input  gnt_a, gnt_b, out_valid, out_data, state_o, hold_cnt
    );

    // Arbiter side.
    modport slave (
        input  req_a, last_a, data_a, req_b, last_b, data_b,
        output gnt_a, gnt_b, out_valid, out_data, state_o, hold_cnt
    );
endinterface

// File: rtl/enum_rr_arbiter.sv
// Two-requester round-robin arbiter sharing one registered output datapath.
// Ownership periods are bounded to MAXHOLD beats, each followed by one
// dead FLUSH cycle before the next arbitration takes effect.
module enum_rr_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAXHOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    enum_rr_arbiter_if.slave   bus
);
    localparam int unsigned HOLD_W    = 4;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAXHOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic               pri_q, pri_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               gnt_a_q, gnt_a_d;
    logic               gnt_b_q, gnt_b_d;

    // Next-state, beat acceptance and release decisions.
    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        hold_d  = hold_q;
        valid_d = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            IDLE, FLUSH: begin
                if (bus.req_a && (!bus.req_b || !pri_q)) begin
                    state_d = OWN_A;
                end else if (bus.req_b) begin
                    state_d = OWN_B;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_A: begin
                if (bus.req_a) begin
                    valid_d = 1'b1;
                    data_d  = bus.data_a;
                end
                if (!bus.req_a || bus.last_a || (hold_q == HOLD_LAST)) begin
                    state_d = FLUSH;
                    hold_d  = '0;
                    pri_d   = 1'b1;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            OWN_B: begin
                if (bus.req_b) begin
                    valid_d = 1'b1;
                    data_d  = bus.data_b;
                end
                if (!bus.req_b || bus.last_b || (hold_q == HOLD_LAST)) begin
                    state_d = FLUSH;
                    hold_d  = '0;
                    pri_d   = 1'b0;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Grants track the state register one-for-one, kept in their own flops.
        gnt_a_d = (state_d == OWN_A);
        gnt_b_d = (state_d == OWN_B);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pri_q   <= 1'b0;
            hold_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
        end
    end

    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.state_o   = state_q;
    assign bus.hold_cnt  = hold_q;
endmodule

// File: tb/tb_enum_rr_arbiter.sv
// Directed bench for enum_rr_arbiter: MAXHOLD=4 and MAXHOLD=1 instances.
module tb_enum_rr_arbiter;
    logic clk = 1'b0;
    logic rst0;
    logic rst1;

    always #5 clk = ~clk;

    enum_rr_arbiter_if #(.WIDTH(8)) bus0 ();
    enum_rr_arbiter_if #(.WIDTH(8)) bus1 ();

    enum_rr_arbiter #(.WIDTH(8), .MAXHOLD(4)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    enum_rr_arbiter #(.WIDTH(8), .MAXHOLD(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       ga;
        logic       gb;
        logic       ov;
        logic [7:0] od;
        logic [3:0] hc;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;

    task automatic drive0(input logic ra, input logic la, input logic [7:0] da,
                          input logic rb, input logic lb, input logic [7:0] db);
        bus0.req_a = ra; bus0.last_a = la; bus0.data_a = da;
        bus0.req_b = rb; bus0.last_b = lb; bus0.data_b = db;
    endtask

    task automatic drive1(input logic ra, input logic la, input logic [7:0] da,
                          input logic rb, input logic lb, input logic [7:0] db);
        bus1.req_a = ra; bus1.last_a = la; bus1.data_a = da;
        bus1.req_b = rb; bus1.last_b = lb; bus1.data_b = db;
    endtask

    task automatic exp0(input string tag, input logic [1:0] st, input logic ga,
                        input logic gb, input logic ov, input logic [7:0] od,
                        input logic [3:0] hc);
        exp_t e;
        e.tag = tag;
        e.v = '{st: st, ga: ga, gb: gb, ov: ov, od: od, hc: hc};
        q0.push_back(e);
    endtask

    task automatic exp1(input string tag, input logic [1:0] st, input logic ga,
                        input logic gb, input logic ov, input logic [7:0] od,
                        input logic [3:0] hc);
        exp_t e;
        e.tag = tag;
        e.v = '{st: st, ga: ga, gb: gb, ov: ov, od: od, hc: hc};
        q1.push_back(e);
    endtask

    // Advance one edge, then compare each DUT that has an expectation pending.
    task automatic tick();
        exp_t e;
        obs_t o;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            o = '{st: bus0.state_o, ga: bus0.gnt_a, gb: bus0.gnt_b,
                  ov: bus0.out_valid, od: bus0.out_data, hc: bus0.hold_cnt};
            checks++;
            assert (o === e.v) else begin
                errors++;
                $error("FAIL %s observed st=%0d ga=%b gb=%b ov=%b od=%h hc=%0d expected st=%0d ga=%b gb=%b ov=%b od=%h hc=%0d",
                       e.tag, o.st, o.ga, o.gb, o.ov, o.od, o.hc,
                       e.v.st, e.v.ga, e.v.gb, e.v.ov, e.v.od, e.v.hc);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            o = '{st: bus1.state_o, ga: bus1.gnt_a, gb: bus1.gnt_b,
                  ov: bus1.out_valid, od: bus1.out_data, hc: bus1.hold_cnt};
            checks++;
            assert (o === e.v) else begin
                errors++;
                $error("FAIL %s observed st=%0d ga=%b gb=%b ov=%b od=%h hc=%0d expected st=%0d ga=%b gb=%b ov=%b od=%h hc=%0d",
                       e.tag, o.st, o.ga, o.gb, o.ov, o.od, o.hc,
                       e.v.st, e.v.ga, e.v.gb, e.v.ov, e.v.od, e.v.hc);
            end
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1;
        rst1 = 1'b1;
        drive0(0, 0, 8'h00, 0, 0, 8'h00);
        drive1(0, 0, 8'h00, 0, 0, 8'h00);

        // Reset state
        exp0("reset", 0, 0, 0, 0, 8'h00, 0); tick();

        // A alone held: four beats, FLUSH, re-grant
        rst0 = 1'b0;
        drive0(1, 0, 8'h11, 0, 0, 8'h00);
        exp0("a_grant",   1, 1, 0, 0, 8'h00, 0); tick();
        exp0("a_beat1",   1, 1, 0, 1, 8'h11, 1); tick();
        exp0("a_beat2",   1, 1, 0, 1, 8'h11, 2); tick();
        exp0("a_beat3",   1, 1, 0, 1, 8'h11, 3); tick();
        exp0("a_beat4",   3, 0, 0, 1, 8'h11, 0); tick();
        exp0("a_regrant", 1, 1, 0, 0, 8'h11, 0); tick();

        // Reset clears pri and data
        rst0 = 1'b1;
        drive0(0, 0, 8'h00, 0, 0, 8'h00);
        exp0("reset2", 0, 0, 0, 0, 8'h00, 0); tick();

        // Both held: A x4, FLUSH, B x4, FLUSH, A
        rst0 = 1'b0;
        drive0(1, 0, 8'h3C, 1, 0, 8'hC3);
        exp0("rr_a0",  1, 1, 0, 0, 8'h00, 0); tick();
        exp0("rr_a1",  1, 1, 0, 1, 8'h3C, 1); tick();
        exp0("rr_a2",  1, 1, 0, 1, 8'h3C, 2); tick();
        exp0("rr_a3",  1, 1, 0, 1, 8'h3C, 3); tick();
        exp0("rr_fa",  3, 0, 0, 1, 8'h3C, 0); tick();
        exp0("rr_b0",  2, 0, 1, 0, 8'h3C, 0); tick();
        exp0("rr_b1",  2, 0, 1, 1, 8'hC3, 1); tick();
        exp0("rr_b2",  2, 0, 1, 1, 8'hC3, 2); tick();
        exp0("rr_b3",  2, 0, 1, 1, 8'hC3, 3); tick();
        exp0("rr_fb",  3, 0, 0, 1, 8'hC3, 0); tick();
        exp0("rr_a_again", 1, 1, 0, 0, 8'hC3, 0); tick();

        // A sends A0, A1(last) while B waits
        drive0(1, 0, 8'hA0, 1, 0, 8'hC3);
        exp0("last_a0", 1, 1, 0, 1, 8'hA0, 1); tick();
        drive0(1, 1, 8'hA1, 1, 0, 8'hC3);
        exp0("last_a1", 3, 0, 0, 1, 8'hA1, 0); tick();
        drive0(0, 0, 8'h00, 1, 0, 8'hB7);
        exp0("last_gnt_b", 2, 0, 1, 0, 8'hA1, 0); tick();

        // Reset mid-ownership of B with hold_cnt=2
        exp0("b_hc1", 2, 0, 1, 1, 8'hB7, 1); tick();
        exp0("b_hc2", 2, 0, 1, 1, 8'hB7, 2); tick();
        rst0 = 1'b1;
        drive0(1, 0, 8'h5A, 1, 0, 8'hB8);
        exp0("mid_reset", 0, 0, 0, 0, 8'h00, 0); tick();
        rst0 = 1'b0;
        exp0("tie_after_reset", 1, 1, 0, 0, 8'h00, 0); tick();

        // A drops after one beat; pri then favors B
        drive0(1, 0, 8'h5A, 0, 0, 8'h00);
        exp0("drop_beat", 1, 1, 0, 1, 8'h5A, 1); tick();
        drive0(0, 0, 8'h00, 0, 0, 8'h00);
        exp0("drop_flush", 3, 0, 0, 0, 8'h5A, 0); tick();
        exp0("drop_idle", 0, 0, 0, 0, 8'h5A, 0); tick();
        drive0(1, 0, 8'hFF, 1, 0, 8'h66);
        exp0("pri_b_tie", 2, 0, 1, 0, 8'h5A, 0); tick();

        // Non-owner's last is ignored
        drive0(1, 1, 8'hFF, 1, 0, 8'h66);
        exp0("ignore_last_a", 2, 0, 1, 1, 8'h66, 1); tick();
        drive0(1, 1, 8'hFF, 0, 0, 8'h00);
        exp0("b_drop", 3, 0, 0, 0, 8'h66, 0); tick();
        exp0("a_after_b", 1, 1, 0, 0, 8'h66, 0); tick();
        drive0(0, 0, 8'h00, 0, 0, 8'h00);
        rst0 = 1'b1;

        // MAXHOLD=1: strict single-beat alternation
        exp1("mh1_reset", 0, 0, 0, 0, 8'h00, 0); tick();
        rst1 = 1'b0;
        drive1(1, 0, 8'hAA, 1, 0, 8'hBB);
        exp1("mh1_ga",  1, 1, 0, 0, 8'h00, 0); tick();
        exp1("mh1_fa",  3, 0, 0, 1, 8'hAA, 0); tick();
        exp1("mh1_gb",  2, 0, 1, 0, 8'hAA, 0); tick();
        exp1("mh1_fb",  3, 0, 0, 1, 8'hBB, 0); tick();
        exp1("mh1_ga2", 1, 1, 0, 0, 8'hBB, 0); tick();
        exp1("mh1_fa2", 3, 0, 0, 1, 8'hAA, 0); tick();

        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
